// File: rtl/pcpu_core.sv
// pcpu_core: 16-bit five-stage (IF/ID/EX/MEM/WB) RISC core, no interlocks, no forwarding, 3 branch delay slots.
// Optional PCPU_DEBUG_PORT_EN adds select_y/y for combinational observation of internal state.
module pcpu_core (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [15:0] i_datain,
    input  logic [15:0] d_datain,
    output logic [7:0]  i_addr,
    output logic [7:0]  d_addr,
    output logic        d_we,
    output logic [15:0] d_dataout
`ifdef PCPU_DEBUG_PORT_EN
    ,
    input  logic [3:0]  select_y,
    output logic [15:0] y
`endif
);

    localparam logic [4:0] OP_NOP  = 5'b00000, OP_HALT = 5'b00001, OP_LOAD = 5'b00010, OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00100, OP_SLA  = 5'b00101, OP_SRL  = 5'b00110, OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_ADD  = 5'b01000, OP_ADDI = 5'b01001, OP_SUB  = 5'b01010, OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP  = 5'b01100, OP_AND  = 5'b01101, OP_OR   = 5'b01110, OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_LDIH = 5'b10000, OP_ADDC = 5'b10001, OP_SUBC = 5'b10010;
    localparam logic [4:0] OP_JUMP = 5'b11000, OP_JMPR = 5'b11001;
    localparam logic [4:0] OP_BZ   = 5'b11010, OP_BNZ  = 5'b11011, OP_BN   = 5'b11100;
    localparam logic [4:0] OP_BNN  = 5'b11101, OP_BC   = 5'b11110, OP_BNC  = 5'b11111;

    typedef enum logic {ST_IDLE = 1'b0, ST_EXEC = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] id_ir_q;
    logic [4:0]  ex_op_q, mem_op_q, wb_op_q;
    logic [2:0]  ex_r1_q, mem_r1_q, wb_r1_q;
    logic [15:0] reg_a_q, reg_b_q, reg_c_q, reg_c1_q;
    logic [15:0] smdr_q, smdr1_q;
    logic        br_taken_q;
    logic        zf_q, nf_q, cf_q;
    logic [15:0] gr_q [8];

    logic [15:0] a_d, b_d, c1_d;
    logic [16:0] alu_res;
    logic        br_taken_d;
    logic        halt_wb, advance;

    logic [4:0] id_op;
    logic [2:0] id_r1, id_r2, id_r3;
    logic [7:0] id_imm8;
    assign id_op   = id_ir_q[15:11];
    assign id_r1   = id_ir_q[10:8];
    assign id_r2   = id_ir_q[6:4];
    assign id_r3   = id_ir_q[2:0];
    assign id_imm8 = id_ir_q[7:0];

    function automatic logic writes_gr(input logic [4:0] op);
        case (op)
            OP_LOAD, OP_SLL, OP_SLA, OP_SRL, OP_SRA, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI,
            OP_AND, OP_OR, OP_XOR, OP_LDIH, OP_ADDC, OP_SUBC: writes_gr = 1'b1;
            default: writes_gr = 1'b0;
        endcase
    endfunction

    function automatic logic sets_flags(input logic [4:0] op);
        case (op)
            OP_SLL, OP_SLA, OP_SRL, OP_SRA, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_CMP,
            OP_AND, OP_OR, OP_XOR, OP_LDIH, OP_ADDC, OP_SUBC: sets_flags = 1'b1;
            default: sets_flags = 1'b0;
        endcase
    endfunction

    // HALT in WB freezes everything behind it; nothing advances that cycle.
    assign halt_wb = (wb_op_q == OP_HALT);
    assign advance = (state_q == ST_EXEC) && enable && !halt_wb;

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable && start)     state_d = ST_EXEC;
            ST_EXEC: if (!enable || halt_wb)  state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        a_d = gr_q[id_r2];
        b_d = '0;
        case (id_op)
            OP_ADDI, OP_SUBI, OP_JMPR, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: begin
                a_d = gr_q[id_r1];
                b_d = {8'h00, id_imm8};
            end
            OP_LDIH: begin
                a_d = gr_q[id_r1];
                b_d = {id_imm8, 8'h00};
            end
            OP_JUMP: begin
                a_d = '0;
                b_d = {8'h00, id_imm8};
            end
            OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR, OP_ADDC, OP_SUBC:
                b_d = gr_q[id_r3];
            OP_SLL, OP_SLA, OP_SRL, OP_SRA, OP_LOAD, OP_STORE:
                b_d = {12'h000, id_ir_q[3:0]};
            default: ;
        endcase
    end

    always_comb begin
        alu_res    = '0;
        br_taken_d = 1'b0;
        case (ex_op_q)
            OP_ADD, OP_ADDI, OP_LDIH, OP_LOAD, OP_STORE, OP_JUMP, OP_JMPR,
            OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC:
                alu_res = {1'b0, reg_a_q} + {1'b0, reg_b_q};
            OP_ADDC:                 alu_res = {1'b0, reg_a_q} + {1'b0, reg_b_q} + {16'h0000, cf_q};
            OP_SUB, OP_SUBI, OP_CMP: alu_res = {1'b0, reg_a_q} - {1'b0, reg_b_q};
            OP_SUBC:                 alu_res = {1'b0, reg_a_q} - {1'b0, reg_b_q} - {16'h0000, cf_q};
            OP_AND:                  alu_res = {1'b0, reg_a_q & reg_b_q};
            OP_OR:                   alu_res = {1'b0, reg_a_q | reg_b_q};
            OP_XOR:                  alu_res = {1'b0, reg_a_q ^ reg_b_q};
            OP_SLL, OP_SLA:          alu_res = {1'b0, reg_a_q << reg_b_q[3:0]};
            OP_SRL:                  alu_res = {1'b0, reg_a_q >> reg_b_q[3:0]};
            OP_SRA:                  alu_res = {1'b0, $unsigned($signed(reg_a_q) >>> reg_b_q[3:0])};
            default: ;
        endcase
        // Branch decision uses the flags as registered while the branch sits in EX.
        case (ex_op_q)
            OP_JUMP, OP_JMPR: br_taken_d = 1'b1;
            OP_BZ:            br_taken_d = zf_q;
            OP_BNZ:           br_taken_d = !zf_q;
            OP_BN:            br_taken_d = nf_q;
            OP_BNN:           br_taken_d = !nf_q;
            OP_BC:            br_taken_d = cf_q;
            OP_BNC:           br_taken_d = !cf_q;
            default: ;
        endcase
    end

    assign pc_d      = br_taken_q ? reg_c_q[7:0] : pc_q + 8'd1;
    assign c1_d      = (mem_op_q == OP_LOAD) ? d_datain : reg_c_q;
    assign i_addr    = pc_q;
    assign d_addr    = reg_c_q[7:0];
    assign d_dataout = smdr1_q;
    assign d_we      = advance && (mem_op_q == OP_STORE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q       <= '0;
            id_ir_q    <= {OP_NOP, 11'h000};
            ex_op_q    <= OP_NOP;
            mem_op_q   <= OP_NOP;
            wb_op_q    <= OP_NOP;
            ex_r1_q    <= '0;
            mem_r1_q   <= '0;
            wb_r1_q    <= '0;
            reg_a_q    <= '0;
            reg_b_q    <= '0;
            reg_c_q    <= '0;
            reg_c1_q   <= '0;
            smdr_q     <= '0;
            smdr1_q    <= '0;
            br_taken_q <= 1'b0;
            zf_q       <= 1'b0;
            nf_q       <= 1'b0;
            cf_q       <= 1'b0;
            // NOTE: the register file is architecturally cleared by reset, so it lives in flops, not a RAM macro.
            gr_q       <= '{default: '0};
        end else if (advance) begin
            pc_q       <= pc_d;
            id_ir_q    <= i_datain;
            ex_op_q    <= id_op;
            ex_r1_q    <= id_r1;
            reg_a_q    <= a_d;
            reg_b_q    <= b_d;
            smdr_q     <= gr_q[id_r1];
            mem_op_q   <= ex_op_q;
            mem_r1_q   <= ex_r1_q;
            reg_c_q    <= alu_res[15:0];
            smdr1_q    <= smdr_q;
            br_taken_q <= br_taken_d;
            if (sets_flags(ex_op_q)) begin
                zf_q <= (alu_res[15:0] == 16'h0000);
                nf_q <= alu_res[15];
                cf_q <= alu_res[16];
            end
            wb_op_q    <= mem_op_q;
            wb_r1_q    <= mem_r1_q;
            reg_c1_q   <= c1_d;
            if (writes_gr(wb_op_q)) gr_q[wb_r1_q] <= reg_c1_q;
        end
    end

`ifdef PCPU_DEBUG_PORT_EN
    always_comb begin
        y = '0;
        case (select_y)
            4'd0: y = {8'h00, pc_q};
            4'd1: y = id_ir_q;
            4'd2: y = reg_a_q;
            4'd3: y = reg_b_q;
            4'd4: y = reg_c_q;
            4'd5: y = reg_c1_q;
            4'd6: y = {13'h0000, zf_q, nf_q, cf_q};
            4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: y = gr_q[select_y[2:0]];
            default: ;
        endcase
    end
`endif

endmodule

// File: tb/tb_pcpu_core.sv
// Directed bench for pcpu_core: load/add/store, delay-slot branch, CMP flags, HALT, stale operand, enable freeze.
module tb_pcpu_core;

    localparam logic [4:0] OP_NOP  = 5'b00000, OP_HALT = 5'b00001, OP_LOAD = 5'b00010, OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00100, OP_SRA  = 5'b00111, OP_ADD  = 5'b01000, OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_CMP  = 5'b01100, OP_LDIH = 5'b10000, OP_BNZ  = 5'b11011;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic [15:0] i_datain, d_datain, d_dataout;
    logic [7:0]  i_addr, d_addr;
    logic        d_we;

    logic [15:0] imem [256];
    logic [15:0] dmem [256];
    logic        tb_we = 1'b0;
    logic [7:0]  tb_addr = '0;
    logic [15:0] tb_data = '0;
    logic [7:0]  held;

    int checks = 0;
    int errors = 0;

    pcpu_core dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .i_datain  (i_datain),
        .d_datain  (d_datain),
        .i_addr    (i_addr),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .d_dataout (d_dataout)
    );

    always #5 clock = ~clock;

    assign i_datain = imem[i_addr];
    assign d_datain = dmem[d_addr];

    always @(posedge clock) begin
        if (d_we)       dmem[d_addr]  <= d_dataout;
        else if (tb_we) dmem[tb_addr] <= tb_data;
    end

    function automatic logic [15:0] rrr(input logic [4:0] op, input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] r3);
        return {op, r1, 1'b0, r2, 1'b0, r3};
    endfunction

    function automatic logic [15:0] rrv(input logic [4:0] op, input logic [2:0] r1, input logic [2:0] r2, input logic [3:0] v);
        return {op, r1, 1'b0, r2, v};
    endfunction

    function automatic logic [15:0] ri(input logic [4:0] op, input logic [2:0] r1, input logic [7:0] imm);
        return {op, r1, imm};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic dmem_write(input logic [7:0] addr, input logic [15:0] data);
        @(negedge clock);
        tb_we = 1'b1; tb_addr = addr; tb_data = data;
        @(negedge clock);
        tb_we = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_pc(input string tag, input logic [7:0] target, input int budget);
        int n = 0;
        while (i_addr !== target && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, {8'h00, i_addr}, {8'h00, target});
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = {OP_NOP, 11'h000};
    endtask

    initial begin
        clear_imem();

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_pc", {8'h00, i_addr}, 16'h0000);
        check("rst_dwe", {15'h0000, d_we}, 16'h0000);
        check("rst_daddr", {8'h00, d_addr}, 16'h0000);
        check("rst_dout", d_dataout, 16'h0000);
        for (int i = 0; i < 8; i++) check($sformatf("rst_gr%0d", i), dut.gr_q[i], 16'h0000);
        check("rst_flags", {13'h0000, dut.zf_q, dut.nf_q, dut.cf_q}, 16'h0000);

        // start is ignored while enable is low
        @(negedge clock);
        reset = 1'b1;
        pulse_start();
        repeat (3) @(negedge clock);
        check("start_no_enable_pc", {8'h00, i_addr}, 16'h0000);

        // Program 1: load/add/store, BNZ with delay slots, CMP, HALT
        dmem_write(8'h00, 16'h00AB);
        dmem_write(8'h01, 16'h3C00);
        imem[8'h00] = rrv(OP_LOAD, 3'd1, 3'd0, 4'd0);
        imem[8'h01] = rrv(OP_LOAD, 3'd2, 3'd0, 4'd1);
        imem[8'h05] = rrr(OP_ADD, 3'd3, 3'd1, 3'd2);
        imem[8'h09] = rrv(OP_STORE, 3'd3, 3'd0, 4'd2);
        imem[8'h0A] = ri(OP_BNZ, 3'd1, 8'h10);
        imem[8'h0B] = ri(OP_ADDI, 3'd4, 8'h01);
        imem[8'h0C] = ri(OP_ADDI, 3'd5, 8'h02);
        imem[8'h0D] = ri(OP_ADDI, 3'd6, 8'h03);
        imem[8'h0E] = ri(OP_ADDI, 3'd7, 8'h55);
        imem[8'h0F] = ri(OP_ADDI, 3'd7, 8'h66);
        imem[8'hBB] = rrr(OP_CMP, 3'd0, 3'd1, 3'd2);
        imem[8'hBC] = {OP_HALT, 11'h000};
        imem[8'hBE] = ri(OP_ADDI, 3'd7, 8'h77);
        imem[8'hBF] = ri(OP_ADDI, 3'd7, 8'h77);
        enable = 1'b1;
        pulse_start();
        wait_pc("p1_halt_pc", 8'hC0, 100);
        repeat (3) @(negedge clock);
        check("p1_pc_frozen", {8'h00, i_addr}, 16'h00C0);
        check("p1_gr1", dut.gr_q[1], 16'h00AB);
        check("p1_gr2", dut.gr_q[2], 16'h3C00);
        check("p1_gr3", dut.gr_q[3], 16'h3CAB);
        check("p1_slot_gr4", dut.gr_q[4], 16'h0001);
        check("p1_slot_gr5", dut.gr_q[5], 16'h0002);
        check("p1_slot_gr6", dut.gr_q[6], 16'h0003);
        check("p1_gr7_untouched", dut.gr_q[7], 16'h0000);
        check("p1_dmem2", dmem[2], 16'h3CAB);
        check("p1_cmp_flags", {13'h0000, dut.zf_q, dut.nf_q, dut.cf_q}, 16'h0003);

        // Asynchronous reset clears state without a clock edge
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("async_rst_pc", {8'h00, i_addr}, 16'h0000);
        check("async_rst_gr3", dut.gr_q[3], 16'h0000);
        check("async_rst_flags", {13'h0000, dut.zf_q, dut.nf_q, dut.cf_q}, 16'h0000);
        @(negedge clock);
        reset = 1'b1;

        // Program 2: stale operand, shifts, LDIH, enable freeze and restart
        clear_imem();
        dmem_write(8'h05, 16'h1234);
        imem[8'h00] = ri(OP_ADDI, 3'd1, 8'h11);
        imem[8'h04] = rrv(OP_LOAD, 3'd1, 3'd0, 4'd5);
        imem[8'h05] = rrr(OP_ADD, 3'd2, 3'd1, 3'd1);
        imem[8'h09] = rrr(OP_ADD, 3'd3, 3'd1, 3'd1);
        imem[8'h0A] = rrv(OP_SLL, 3'd6, 3'd1, 4'd4);
        imem[8'h0B] = ri(OP_LDIH, 3'd7, 8'h80);
        imem[8'h0F] = rrv(OP_SRA, 3'd7, 3'd7, 4'd3);
        imem[8'h13] = rrv(OP_STORE, 3'd7, 3'd0, 4'd6);
        imem[8'h14] = rrv(OP_STORE, 3'd3, 3'd0, 4'd7);
        imem[8'h15] = {OP_HALT, 11'h000};
        pulse_start();
        repeat (6) @(negedge clock);
        held = i_addr;
        enable = 1'b0;
        repeat (5) @(negedge clock);
        check("freeze_pc_hold", {8'h00, i_addr}, {8'h00, held});
        enable = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("restart_pc_hold", {8'h00, i_addr}, {8'h00, held});
        @(negedge clock);
        check("restart_pc_next", {8'h00, i_addr}, {8'h00, held + 8'd1});
        wait_pc("p2_halt_pc", 8'h19, 100);
        repeat (3) @(negedge clock);
        check("p2_pc_frozen", {8'h00, i_addr}, 16'h0019);
        check("p2_gr1", dut.gr_q[1], 16'h1234);
        check("p2_stale_gr2", dut.gr_q[2], 16'h0022);
        check("p2_gr3", dut.gr_q[3], 16'h2468);
        check("p2_sll_gr6", dut.gr_q[6], 16'h2340);
        check("p2_sra_gr7", dut.gr_q[7], 16'hF000);
        check("p2_dmem6", dmem[6], 16'hF000);
        check("p2_dmem7", dmem[7], 16'h2468);
        check("p2_sra_flags", {13'h0000, dut.zf_q, dut.nf_q, dut.cf_q}, 16'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
